// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the combinational
// instruction ROM, presents registered instructions to decode over a
// valid/ready handshake and time-shares the ROM with a debug read port
// that preempts fetch after a bounded number of denied cycles.
module instr_fetch_ctrl #(
    parameter int unsigned       ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int unsigned       DBG_MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    input  logic              halt,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [31:0]       dbg_data,
    output logic              halted
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] PC_RST     = RESET_PC & ALIGN_MASK;
    localparam logic [2:0]        WAIT_MAX   = 3'(DBG_MAX_WAIT);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        wait_cnt;
    logic              fetch_want;
    logic              dbg_grant;
    logic              fetch_grant;

    // State register for the run/halt sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state, ROM port arbitration and address selection
    always_comb begin
        state_next  = state;
        fetch_want  = 1'b0;
        dbg_grant   = 1'b0;
        fetch_grant = 1'b0;
        mem_addr    = pc;

        case (state)
            RUN:     if (halt)  state_next = HALTED;
            HALTED:  if (!halt) state_next = RUN;
            default: state_next = RUN;
        endcase

        fetch_want  = (state == RUN) && !br_valid && (!instr_valid || instr_ready);
        // Debug wins when fetch has nothing to do, or once it has been
        // denied long enough; the ack cycle itself is never re-granted.
        dbg_grant   = dbg_req && !dbg_ack && (!fetch_want || (wait_cnt == WAIT_MAX));
        fetch_grant = fetch_want && !dbg_grant;
        mem_addr    = (dbg_grant ? dbg_addr : pc) & ALIGN_MASK;
    end

    assign halted = (state == HALTED);

    // PC, presented instruction and flush/consume handling
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= PC_RST;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else if (br_valid) begin
            pc          <= br_target & ALIGN_MASK;
            instr_valid <= 1'b0;
        end else if (fetch_grant) begin
            instr       <= mem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + ADDR_W'(4);
        end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

    // Debug read capture and starvation counter
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_ack  <= 1'b0;
            dbg_data <= '0;
            wait_cnt <= '0;
        end else begin
            dbg_ack <= dbg_grant;
            if (dbg_grant) begin
                dbg_data <= mem_data;
            end
            if (!dbg_req || dbg_grant) begin
                wait_cnt <= '0;
            end else if (!dbg_ack && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
        end
    end

endmodule
